// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver. It turns the asynchronous RX pad line into
// parallel words. Data width, parity and the number of stop bits can be set.
// It reports parity and framing errors and ignores start-bit glitches.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 4)
//   DATA_BITS     data bits per frame, 5..9, LSB first
//   PARITY_EN     1 = a parity bit follows the data bits
//   PARITY_ODD    1 = odd parity, 0 = even (only used when PARITY_EN = 1)
//   STOP_BITS     1 or 2
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Reset       asynchronous active-high reset
//   i_RX_Serial   serial line, idle high, not synchronised to i_Clock
//   o_RX_DV       one-cycle pulse when a new word is available
//   o_RX_Byte     last received word, held until the next o_RX_DV
//   o_Parity_Err  parity error of the last word, updated with o_RX_DV
//   o_Frame_Err   a stop bit of the last word was low, updated with o_RX_DV
//   o_Busy        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Start-bit check point: the middle of the start bit. Every later sample
  // is taken a full bit period after the previous one, so it also falls in
  // the middle of its bit.
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Two-flop synchroniser. It is preset to the idle level so that reset
  // cannot create a false start bit.
  logic rx_meta_q;
  logic rx_sync_q;

  state_t               state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 dv_q,       dv_d;
  logic [DATA_BITS-1:0] word_q,     word_d;
  logic                 perr_q,     perr_d;
  logic                 ferr_q,     ferr_d;

  logic bit_tick;
  logic frame_now;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      dv_q       <= 1'b0;
      word_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      dv_q       <= dv_d;
      word_q     <= word_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bit_tick  = (cnt_q == FULL_CNT);
  // A framing error is any low stop sample in this frame, including this one.
  assign frame_now = ferr_acc_q | ~rx_sync_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    dv_d       = 1'b0;
    word_d     = word_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        if (!rx_sync_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            // Confirmed start bit: clear the error flags from the previous frame.
            state_d    = S_DATA;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            // Line went high before mid-bit: treat it as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          // Shift right so the first (LSB) bit ends up at index 0.
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          cnt_d      = '0;
          perr_acc_d = ((^shift_q) ^ rx_sync_q) != ODD_BIT;
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          cnt_d      = '0;
          ferr_acc_d = frame_now;
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            dv_d       = 1'b1;
            word_d     = shift_q;
            perr_d     = perr_acc_q;
            ferr_d     = frame_now;
            // A good frame returns to IDLE right away, so a start bit that
            // follows with no idle gap is still caught. A bad frame (for
            // example a break) must see the line go high again before the
            // next word can start.
            state_d    = frame_now ? S_WAIT_HIGH : S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = word_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule
